led_game_driver: RTL and testbench

Stateful counterpart to the combinational Status next-state block of the LED game.
- Conditions the raw push-buttons into the 7-bit one-cycle event vector that Status consumes.
- Holds the 4-bit game status register and feeds it back to Status as its current state.
- Commits Status's next-state output on each game step.
- Renders the status on 8 LEDs and keeps a win score.

---
 rtl/led_game_driver.sv | 109 ++++++++++
 tb/tb_led_game_driver.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_game_driver.sv
// Stateful wrapper around the LED game's combinational Status block: button
// conditioning, step timing, the status register, the LED pattern and the win score.
module led_game_driver #(
    parameter int TICK_DIV = 50,
    parameter int DEBOUNCE = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] buttons,
    input  logic [3:0] next_status,
    output logic [6:0] inputs,
    output logic [3:0] current,
    output logic       step,
    output logic [7:0] leds,
    output logic [7:0] score,
    output logic       error
);

    localparam int DB_W   = $clog2(DEBOUNCE + 1);
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [6:0]        sync1;
    logic [6:0]        sync2;
    logic [6:0]        level;
    logic [6:0]        flips;
    logic [DB_W-1:0]   db_cnt [7];
    logic [TICK_W-1:0] tick;
    logic              fire;
    logic              legal;
    logic [3:0]        new_cur;
    logic [7:0]        new_leds;

    // A bit flips on the DEBOUNCE-th consecutive sample that disagrees with its level.
    always_comb begin
        flips = '0;
        for (int i = 0; i < 7; i++) begin
            flips[i] = (sync2[i] != level[i]) && (db_cnt[i] == DB_LAST);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            level  <= '0;
            inputs <= '0;
            for (int i = 0; i < 7; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1  <= buttons;
            sync2  <= sync1;
            level  <= level ^ flips;
            inputs <= flips & ~level;
            for (int i = 0; i < 7; i++) begin
                if ((sync2[i] == level[i]) || flips[i]) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    always_comb begin
        fire     = (tick == TICK_LAST) || (|inputs);
        legal    = (next_status <= 4'd9);
        new_cur  = legal ? next_status : 4'd0;
        new_leds = 8'h01;
        if (new_cur == 4'd9) begin
            new_leds = (current == 4'd9) ? ~leds : 8'hFF;
        end else if (new_cur == 4'd8) begin
            new_leds = 8'hFF;
        end else begin
            new_leds = 8'h01 << new_cur[2:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tick    <= '0;
            current <= 4'd0;
            leds    <= 8'h01;
            score   <= 8'd0;
            step    <= 1'b0;
            error   <= 1'b0;
        end else begin
            step <= fire;
            if (fire) begin
                tick    <= '0;
                current <= new_cur;
                leds    <= new_leds;
                if (!legal) begin
                    error <= 1'b1;
                end
                // Only an entry into 9 is a win; staying at 9 is not.
                if ((new_cur == 4'd9) && (current != 4'd9) && (score != 8'hFF)) begin
                    score <= score + 8'd1;
                end
            end else begin
                tick <= tick + TICK_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_led_game_driver.sv
// Bench for led_game_driver: directed scenarios plus random buttons, each cycle
// checked against a window/history based model of the game driver.
module tb_led_game_driver;

    localparam int TICK_DIV = 50;
    localparam int DEBOUNCE = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] buttons;
    logic [3:0] next_status;
    logic [6:0] inputs;
    logic [3:0] current;
    logic       step;
    logic [7:0] leds;
    logic [7:0] score;
    logic       error;

    int vectors    = 0;
    int miscompares = 0;

    led_game_driver #(.TICK_DIV(TICK_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clock       (clock),
        .reset       (reset),
        .buttons     (buttons),
        .next_status (next_status),
        .inputs      (inputs),
        .current     (current),
        .step        (step),
        .leds        (leds),
        .score       (score),
        .error       (error)
    );

    always #5 clock = ~clock;

    // Reference model state
    logic [6:0] m_inputs;
    logic [6:0] m_level;
    logic [3:0] m_current;
    logic       m_step;
    logic       m_error;
    logic [7:0] m_leds;
    int         m_score;
    int         edge_n    = 0;
    int         last_step = 0;
    int         nine_run  = 0;
    logic [6:0] raw_q [$];
    logic [6:0] sync_q [$];

    function automatic logic [28:0] dut_vec();
        return {inputs, current, step, leds, score, error};
    endfunction

    function automatic logic [28:0] mdl_vec();
        return {m_inputs, m_current, m_step, m_leds, 8'(m_score), m_error};
    endfunction

    task automatic model_edge();
        logic [6:0] sync;
        logic [6:0] fl;
        logic [3:0] nxt;
        bit         fire;
        bit         all_diff;
        edge_n++;
        if (reset) begin
            m_inputs = '0; m_level = '0; m_current = '0; m_step = 1'b0;
            m_error = 1'b0; m_leds = 8'h01; m_score = 0; nine_run = 0;
            raw_q.delete(); sync_q.delete();
            last_step = edge_n;
            return;
        end
        fire = ((edge_n - last_step) == TICK_DIV) || (m_inputs != 0);
        // Synchronized value seen now is the raw sample from two edges ago.
        raw_q.push_back(buttons);
        if (raw_q.size() > 3) void'(raw_q.pop_front());
        sync = (raw_q.size() == 3) ? raw_q[0] : 7'd0;
        sync_q.push_back(sync);
        if (sync_q.size() > DEBOUNCE) void'(sync_q.pop_front());
        fl = '0;
        if (sync_q.size() == DEBOUNCE) begin
            for (int i = 0; i < 7; i++) begin
                all_diff = 1'b1;
                for (int j = 0; j < DEBOUNCE; j++) begin
                    if (sync_q[j][i] == m_level[i]) all_diff = 1'b0;
                end
                fl[i] = all_diff;
            end
        end
        m_step = fire;
        if (fire) begin
            last_step = edge_n;
            if (next_status > 4'd9) begin
                nxt = 4'd0;
                m_error = 1'b1;
            end else begin
                nxt = next_status;
            end
            if (nxt == 4'd9) begin
                if (m_current == 4'd9) begin
                    nine_run++;
                end else begin
                    nine_run = 0;
                    if (m_score < 255) m_score++;
                end
                m_leds = (nine_run % 2 == 1) ? 8'h00 : 8'hFF;
            end else if (nxt == 4'd8) begin
                m_leds = 8'hFF;
            end else begin
                m_leds = 8'(1 << nxt);
            end
            m_current = nxt;
        end
        m_inputs = fl & ~m_level;
        m_level  = m_level ^ fl;
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        buttons = '0;
        next_status = 4'd3;
        reset = 1'b1;
        tick();
        tick();
        vectors++;
        if (dut_vec() !== {7'd0, 4'd0, 1'b0, 8'h01, 8'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values: got %h want %h", dut_vec(), {7'd0, 4'd0, 1'b0, 8'h01, 8'd0, 1'b0});
        end
        reset = 1'b0;
    endtask

    task automatic test_auto_step();
        for (int k = 1; k <= 51; k++) begin
            tick();
            vectors++;
            if (dut_vec() !== mdl_vec()) begin
                miscompares++;
                $display("FAIL auto_model k=%0d: got %h want %h", k, dut_vec(), mdl_vec());
            end
            if (k == 49) begin
                vectors++;
                if (step !== 1'b0) begin
                    miscompares++;
                    $display("FAIL auto_early: step got %b want 0", step);
                end
            end
            if (k == 50) begin
                vectors++;
                if ({step, current, leds} !== {1'b1, 4'd3, 8'h08}) begin
                    miscompares++;
                    $display("FAIL auto_first_step: got %b/%0d/%h want 1/3/08", step, current, leds);
                end
            end
            if (k == 51) begin
                vectors++;
                if (step !== 1'b0) begin
                    miscompares++;
                    $display("FAIL auto_step_width: step got %b want 0", step);
                end
            end
        end
    endtask

    task automatic test_debounce();
        next_status = 4'd5;
        buttons = 7'b0000100;
        for (int k = 1; k <= 7; k++) begin
            tick();
            vectors++;
            if (dut_vec() !== mdl_vec()) begin
                miscompares++;
                $display("FAIL deb_model k=%0d: got %h want %h", k, dut_vec(), mdl_vec());
            end
            vectors++;
            if (inputs !== ((k == 6) ? 7'b0000100 : 7'b0000000)) begin
                miscompares++;
                $display("FAIL deb_event k=%0d: inputs got %b", k, inputs);
            end
        end
        vectors++;
        if ({step, current} !== {1'b1, 4'd5}) begin
            miscompares++;
            $display("FAIL deb_load: got %b/%0d want 1/5", step, current);
        end
        // Event step restarts the period: next automatic step 50 edges later.
        next_status = 4'd6;
        for (int k = 1; k <= 50; k++) begin
            tick();
            vectors++;
            if (step !== (k == 50)) begin
                miscompares++;
                $display("FAIL deb_restart k=%0d: step got %b", k, step);
            end
        end
        buttons = '0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            vectors++;
            if (dut_vec() !== mdl_vec() || inputs !== 7'd0) begin
                miscompares++;
                $display("FAIL deb_release k=%0d: got %h want %h", k, dut_vec(), mdl_vec());
            end
        end
        buttons = 7'b0000100;
        for (int k = 1; k <= 13; k++) begin
            if (k == 4) buttons = '0;
            tick();
            vectors++;
            if (dut_vec() !== mdl_vec() || inputs !== 7'd0) begin
                miscompares++;
                $display("FAIL deb_glitch k=%0d: got %h want %h", k, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_coincide();
        int steps_seen = 0;
        buttons = '0;
        next_status = 4'd2;
        do_reset();
        for (int k = 1; k <= 100; k++) begin
            if (k == 44) buttons = 7'b0000001;
            tick();
            vectors++;
            if (dut_vec() !== mdl_vec()) begin
                miscompares++;
                $display("FAIL coin_model k=%0d: got %h want %h", k, dut_vec(), mdl_vec());
            end
            if (k == 49) begin
                vectors++;
                if (inputs !== 7'b0000001) begin
                    miscompares++;
                    $display("FAIL coin_event: inputs got %b want 0000001", inputs);
                end
            end
            if (k <= 60 && step === 1'b1) steps_seen++;
            if (k == 100) begin
                vectors++;
                if (step !== 1'b1) begin
                    miscompares++;
                    $display("FAIL coin_next_auto: step got %b want 1", step);
                end
            end
        end
        vectors++;
        if (steps_seen != 1) begin
            miscompares++;
            $display("FAIL coin_single: steps got %0d want 1", steps_seen);
        end
        buttons = '0;
    endtask

    task automatic test_win();
        logic [3:0] seq_ns   [4] = '{4'd8, 4'd9, 4'd9, 4'd9};
        logic [7:0] seq_leds [4] = '{8'hFF, 8'hFF, 8'h00, 8'hFF};
        do_reset();
        for (int s = 0; s < 4; s++) begin
            next_status = seq_ns[s];
            for (int k = 1; k <= 50; k++) begin
                tick();
                vectors++;
                if (dut_vec() !== mdl_vec()) begin
                    miscompares++;
                    $display("FAIL win_model s=%0d k=%0d: got %h want %h", s, k, dut_vec(), mdl_vec());
                end
            end
            vectors++;
            if ({step, leds, score} !== {1'b1, seq_leds[s], (s == 0) ? 8'd0 : 8'd1}) begin
                miscompares++;
                $display("FAIL win_step s=%0d: step/leds/score got %b/%h/%0d", s, step, leds, score);
            end
        end
        for (int w = 0; w < 512; w++) begin
            next_status = (w % 2 == 0) ? 4'd0 : 4'd9;
            for (int k = 1; k <= 50; k++) begin
                tick();
                vectors++;
                if (dut_vec() !== mdl_vec()) begin
                    miscompares++;
                    $display("FAIL sat_model w=%0d k=%0d: got %h want %h", w, k, dut_vec(), mdl_vec());
                end
            end
        end
        vectors++;
        if (score !== 8'hFF) begin
            miscompares++;
            $display("FAIL win_saturate: score got %h want FF", score);
        end
    endtask

    task automatic test_error();
        logic [3:0] seq_ns [3] = '{4'd7, 4'd12, 4'd5};
        do_reset();
        for (int s = 0; s < 3; s++) begin
            next_status = seq_ns[s];
            for (int k = 1; k <= 50; k++) begin
                tick();
                vectors++;
                if (dut_vec() !== mdl_vec()) begin
                    miscompares++;
                    $display("FAIL err_model s=%0d k=%0d: got %h want %h", s, k, dut_vec(), mdl_vec());
                end
            end
            if (s == 1) begin
                vectors++;
                if ({current, leds, error} !== {4'd0, 8'h01, 1'b1}) begin
                    miscompares++;
                    $display("FAIL err_illegal: got %0d/%h/%b want 0/01/1", current, leds, error);
                end
            end
            if (s == 2) begin
                vectors++;
                if ({current, error} !== {4'd5, 1'b1}) begin
                    miscompares++;
                    $display("FAIL err_sticky: got %0d/%b want 5/1", current, error);
                end
            end
        end
        do_reset();
        vectors++;
        if (error !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear: error got %b want 0", error);
        end
    endtask

    task automatic test_reset_mid();
        next_status = 4'd4;
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            if (k == 27) buttons = 7'b0100000;
            tick();
        end
        do_reset();
        vectors++;
        if (dut_vec() !== {7'd0, 4'd0, 1'b0, 8'h01, 8'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL midreset_values: got %h", dut_vec());
        end
        for (int k = 1; k <= 7; k++) begin
            tick();
            vectors++;
            if (dut_vec() !== mdl_vec() || inputs !== ((k == 6) ? 7'b0100000 : 7'd0)) begin
                miscompares++;
                $display("FAIL midreset_event k=%0d: got %h want %h", k, dut_vec(), mdl_vec());
            end
        end
        buttons = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < 7; i++) begin
                if ($urandom_range(0, 7) == 0) buttons[i] = ~buttons[i];
            end
            next_status = 4'($urandom_range(0, 10) == 10 ? $urandom_range(10, 15) : $urandom_range(0, 9));
            reset = ($urandom_range(0, 499) == 0);
            tick();
            vectors++;
            if (dut_vec() !== mdl_vec()) begin
                miscompares++;
                $display("FAIL rand_model k=%0d: got %h want %h", k, dut_vec(), mdl_vec());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        buttons = '0;
        next_status = '0;
        test_reset();
        test_auto_step();
        test_debounce();
        test_coincide();
        test_win();
        test_error();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
